// File: rtl/srl_var_dly.sv
// Variable-tap WIDTH x DEPTH shift-register delay line with clock enable, flush,
// fill tracking and an optional output register.
module srl_var_dly #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 32,
    parameter int REG_OUT = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             CLR,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic [WIDTH-1:0] QLAST,
    output logic             FULL
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] sr [DEPTH];
    logic [DEPTH-1:0] wmask;
    logic [CW-1:0]    fcnt;
    logic [AW-1:0]    ea;
    logic             shift;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;
    logic             full_c;

    assign shift = CE & ~CLR;

    // NOTE: the shift array has no reset so it maps onto SRL primitives; stale
    // contents are hidden by the written-since-clear mask instead of being cleared.
    always_ff @(posedge CLK) begin
        if (shift) begin
            sr[0] <= I;
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    // The mask bit travels with its stage, so a stage becomes visible only once
    // data shifted in after the last clear has reached it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wmask <= '0;
            fcnt  <= '0;
        end else if (CLR) begin
            wmask <= '0;
            fcnt  <= '0;
        end else if (CE) begin
            wmask <= {wmask[DEPTH-2:0], 1'b1};
            if (fcnt != CW'(DEPTH)) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Out-of-range taps clamp to the last stage rather than wrapping.
    always_comb begin
        ea = A;
        if (int'(A) > DEPTH - 1) begin
            ea = AW'(DEPTH - 1);
        end
    end

    assign tap_valid = wmask[ea];
    assign tap_data  = tap_valid ? sr[ea] : '0;
    assign full_c    = (fcnt == CW'(DEPTH));
    assign QLAST     = wmask[DEPTH-1] ? sr[DEPTH-1] : '0;

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] dout_q;
        logic             valid_q;
        logic             full_q;

        // Runs every edge regardless of CE so tap changes still reach the output.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
                full_q  <= 1'b0;
            end else begin
                dout_q  <= tap_data;
                valid_q <= tap_valid;
                full_q  <= full_c;
            end
        end

        assign DOUT  = dout_q;
        assign VALID = valid_q;
        assign FULL  = full_q;
    end else begin : g_comb
        assign DOUT  = tap_data;
        assign VALID = tap_valid;
        assign FULL  = full_c;
    end

endmodule

// File: tb/tb_srl_var_dly.sv
// Self-checking bench: three srl_var_dly configurations against a queue-based model.
module tb_srl_var_dly;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CE;
    logic       CLR;
    logic [4:0] A;
    logic [7:0] I;

    logic [7:0] dout0, qlast0, dout1, qlast1, dout2, qlast2;
    logic       valid0, full0, valid1, full1, valid2, full2;

    int checks = 0;
    int errors = 0;

    // Model: everything shifted in since the last clear, newest at the back.
    logic [7:0] hist[$];
    int         n = 0;
    logic [7:0] exp_r_dout;
    logic       exp_r_valid;
    logic       exp_r_full;

    always #5 CLK = ~CLK;

    srl_var_dly #(.WIDTH(8), .DEPTH(32), .REG_OUT(0)) u_d32 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .A(A), .I(I),
        .DOUT(dout0), .VALID(valid0), .QLAST(qlast0), .FULL(full0));

    srl_var_dly #(.WIDTH(8), .DEPTH(20), .REG_OUT(0)) u_d20 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .A(A), .I(I),
        .DOUT(dout1), .VALID(valid1), .QLAST(qlast1), .FULL(full1));

    srl_var_dly #(.WIDTH(8), .DEPTH(32), .REG_OUT(1)) u_r32 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .A(A), .I(I),
        .DOUT(dout2), .VALID(valid2), .QLAST(qlast2), .FULL(full2));

    function automatic int eff(int d, int a);
        return (a > d - 1) ? d - 1 : a;
    endfunction

    function automatic logic [7:0] m_dout(int d, int a);
        int e = eff(d, a);
        if (n > e) return hist[hist.size() - 1 - e];
        return 8'h00;
    endfunction

    function automatic logic m_valid(int d, int a);
        return n > eff(d, a);
    endfunction

    function automatic logic [7:0] m_qlast(int d);
        if (n >= d) return hist[hist.size() - d];
        return 8'h00;
    endfunction

    function automatic logic m_full(int d);
        return n >= d;
    endfunction

    task automatic model_clear();
        hist.delete();
        n = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("d32_dout",  dout0,  m_dout(32, A));
        check("d32_valid", valid0, m_valid(32, A));
        check("d32_qlast", qlast0, m_qlast(32));
        check("d32_full",  full0,  m_full(32));
        check("d20_dout",  dout1,  m_dout(20, A));
        check("d20_valid", valid1, m_valid(20, A));
        check("d20_qlast", qlast1, m_qlast(20));
        check("d20_full",  full1,  m_full(20));
        check("r32_dout",  dout2,  exp_r_dout);
        check("r32_valid", valid2, exp_r_valid);
        check("r32_full",  full2,  exp_r_full);
        check("r32_qlast", qlast2, m_qlast(32));
    endtask

    // One clock: the registered instance captures what the combinational view
    // shows just before the edge; then the model applies the edge's rules.
    task automatic tick();
        if (RST_N) begin
            exp_r_dout  = m_dout(32, A);
            exp_r_valid = m_valid(32, A);
            exp_r_full  = m_full(32);
        end else begin
            exp_r_dout  = 8'h00;
            exp_r_valid = 1'b0;
            exp_r_full  = 1'b0;
        end
        @(posedge CLK);
        if (!RST_N || CLR) begin
            model_clear();
        end else if (CE) begin
            hist.push_back(I);
            n++;
            if (hist.size() > 32) void'(hist.pop_front());
        end
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; CE = 1'b0; CLR = 1'b0; A = 5'd0; I = 8'h00;
        exp_r_dout = 8'h00; exp_r_valid = 1'b0; exp_r_full = 1'b0;
        @(negedge CLK);
        check_all();
        check("rst_dout", dout0, 8'h00);
        check("rst_valid", valid0, 1'b0);
        RST_N = 1'b1;

        // Basic delay, A=4, ramp from 0x01.
        A = 5'd4; CE = 1'b1;
        for (int e = 0; e < 10; e++) begin
            I = 8'(e + 1);
            tick();
            if (e < 4) begin
                check("basic_pre_valid", valid0, 1'b0);
                check("basic_pre_dout", dout0, 8'h00);
            end
            if (e == 4) begin
                check("basic_dout_e4", dout0, 8'h01);
                check("basic_valid_e4", valid0, 1'b1);
                check("reg_valid_e4", valid2, 1'b0);
            end
            if (e == 5) begin
                check("reg_dout_e5", dout2, 8'h01);
                check("reg_valid_e5", valid2, 1'b1);
            end
        end

        // Clamp and FULL on the 20-deep line with A beyond its range.
        CLR = 1'b1; tick(); CLR = 1'b0;
        A = 5'd31;
        for (int e = 0; e < 25; e++) begin
            I = 8'(8'h40 + e);
            tick();
            if (e == 18) check("clamp_full_e18", full1, 1'b0);
            if (e == 19) begin
                check("clamp_full_e19", full1, 1'b1);
                check("clamp_dout_e19", dout1, 8'h40);
            end
        end

        // CE gaps, then tap changes between edges.
        CLR = 1'b1; tick(); CLR = 1'b0;
        A = 5'd2;
        begin
            logic [4:0] pat;
            pat = 5'b10101;
            for (int e = 0; e < 5; e++) begin
                CE = pat[4-e];
                I  = 8'(8'h11 + e / 2);
                tick();
            end
        end
        check("gap_first_datum", dout0, 8'h11);
        A = 5'd10; #1;
        check_all();
        check("gap_a10_valid", valid0, 1'b0);
        A = 5'd1; #1;
        check_all();
        check("gap_a1_dout", dout0, 8'h12);
        CE = 1'b1;
        for (int e = 0; e < 3; e++) begin
            I = 8'(8'h20 + e);
            tick();
        end

        // Flush from FULL with CE=1; the sampled 0xAA must never appear.
        A = 5'd5;
        for (int e = 0; e < 35; e++) begin
            I = 8'(8'h60 + e);
            tick();
        end
        check("flush_pre_full", full0, 1'b1);
        CLR = 1'b1; I = 8'hAA;
        tick();
        check("flush_dout", dout0, 8'h00);
        check("flush_full", full0, 1'b0);
        check("flush_qlast", qlast0, 8'h00);
        CLR = 1'b0; A = 5'd0; I = 8'h55;
        tick();
        check("flush_next_dout", dout0, 8'h55);
        A = 5'd1; I = 8'h56;
        tick();
        check("flush_no_aa", dout0, 8'h55);

        // Asynchronous reset between edges after 10 shifts.
        CLR = 1'b1; tick(); CLR = 1'b0;
        A = 5'd3;
        for (int e = 0; e < 10; e++) begin
            I = 8'(8'h80 + e);
            tick();
        end
        #2 RST_N = 1'b0;
        #1;
        model_clear();
        exp_r_dout = 8'h00; exp_r_valid = 1'b0; exp_r_full = 1'b0;
        check_all();
        check("arst_dout", dout0, 8'h00);
        check("arst_reg_dout", dout2, 8'h00);
        tick();
        RST_N = 1'b1;
        for (int e = 0; e < 6; e++) begin
            I = 8'(8'h01 + e);
            tick();
        end
        check("arst_restart_dout", dout0, 8'h03);

        // Random traffic with occasional flushes and mid-cycle tap changes.
        for (int e = 0; e < 600; e++) begin
            CE  = ($urandom_range(0, 3) != 0);
            CLR = ($urandom_range(0, 40) == 0);
            A   = 5'($urandom_range(0, 31));
            I   = 8'($urandom);
            tick();
            if ($urandom_range(0, 7) == 0) begin
                A = 5'($urandom_range(0, 31));
                #1;
                check_all();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srl_var_dly.md
# srl_var_dly

Parametrised, multi-bit successor to the single-bit 16-deep SRL delay primitive. It is a WIDTH-bit shift-register delay line, up to DEPTH stages deep, with a run-time tap select and clock enable. It adds four things the primitive lacks: asynchronous clearable contents, a synchronous flush, fill tracking (VALID), and an optional registered output. It sits in the data path wherever L1A/LCT-aligned data must be delayed by a programmable number of clocks.

## Interface
- WIDTH, 8, data bits per stage (1..64)
- DEPTH, 32, number of stages (2..256; need not be a power of 2)
- REG_OUT, 0, 0 = combinational tap output (SRL-like); 1 = registered DOUT/VALID, +1 clock latency
- AW (localparam), clog2(DEPTH), width of A

- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset; asynchronous and active-low
- CE  in  1  shift enable; one stage shift per CLK edge with CE=1
- CLR  in  1  synchronous flush of contents and fill count
- A  in  AW  tap address = delay-1 (5-clock delay ⇒ A=4)
- I  in  WIDTH  data input
- DOUT  out  WIDTH  data at stage min(A, DEPTH-1)
- VALID  out  1  selected stage holds data shifted in since the last reset/flush
- QLAST  out  WIDTH  stage DEPTH-1, for cascading into the next delay line
- FULL  out  1  all DEPTH stages hold shifted data

## Operation
- Storage is sr[0..DEPTH-1], each WIDTH bits. On an edge with CE=1 and CLR=0: sr[0]←I and sr[k]←sr[k-1].
- Fill counter fcnt, range 0..DEPTH, saturating. It increments on each shifting edge and holds at DEPTH.
- Effective tap ea = min(A, DEPTH-1). Out-of-range A is clamped, never wrapped.
- Outputs:
  - DOUT = sr[ea]
  - VALID = (fcnt > ea)
  - FULL = (fcnt == DEPTH)
  - QLAST = sr[DEPTH-1], always combinational regardless of REG_OUT
- Changing A takes effect on the same cycle (REG_OUT=0) or the next edge (REG_OUT=1). Contents are not disturbed.
- A change does not restart fill. VALID reflects the fcnt already accumulated:
  - raising A above fcnt-1 drops VALID
  - lowering A re-asserts VALID immediately
- CLR=1 at an edge zeroes all stages and fcnt. CLR has priority over CE; the I sampled that edge is discarded.
- RST_N=0 asynchronously zeroes all stages, fcnt, and the REG_OUT registers. Reset asserted mid-stream loses all in-flight data.
- CE=0 freezes contents and fcnt. With REG_OUT=1 the output register still updates every edge; it tracks A changes but not new data.
- Storage must infer SRL primitives: there is no reset on the shift array. Clearing is implemented by zero-forcing through a per-stage "written since clear" mask, so no stage is ever read out as nonzero after reset or flush.

## Timing
- Reset values: DOUT=0, VALID=0, QLAST=0, FULL=0.
- REG_OUT=0: I presented at CE edge k appears on DOUT after edge k+A (A+1 clocks with continuous CE). VALID rises after the (A+1)-th shifting edge.
- REG_OUT=1: every output except QLAST lags the REG_OUT=0 behaviour by exactly one CLK edge. VALID lags identically to DOUT.
- Gaps in CE stretch latency. Delay is counted in CE-qualified edges, not clocks.
- QLAST: data at edge k appears after edge k+DEPTH-1.
- FULL asserts after the DEPTH-th shifting edge. It clears only on CLR or RST_N.
- Simultaneous CLR and CE: flush wins; the next shifting edge produces fcnt=1.
- RST_N deassertion is synchronised externally. The first shifting edge may be the first CLK after release.

## Test plan
- Basic delay: WIDTH=8, DEPTH=32, REG_OUT=0, A=4, CE=1, I=0x01,0x02,... from cycle 0. Required: DOUT=0x01 after edge 4; VALID=0 through edge 3, =1 from edge 4; DOUT=0 before edge 4.
- Clamp and FULL: DEPTH=20, A=31, continuous ramp. Required: DOUT equals QLAST; VALID and FULL both rise after edge 19.
- CE gaps and A change: A=2, CE pattern 1,0,1,0,1. Required: first datum on DOUT only after the 3rd CE edge. Then switch A to 10 with fcnt=3: VALID drops the same cycle; switch back to A=1: VALID=1 and DOUT=2nd-newest datum.
- Flush: fill to FULL, then assert CLR with CE=1 and I=0xAA. Required: after the edge, DOUT=0, VALID=0, FULL=0, QLAST=0; 0xAA is absent from the line; the next CE edge yields fcnt=1.
- Async reset mid-stream: drop RST_N between edges after 10 shifts. Required: all outputs 0 immediately, without waiting for an edge; after release, behaviour matches a fresh start.
- REG_OUT=1 repeat of the basic-delay scenario. Required: DOUT=0x01 and VALID=1 after edge 5; QLAST timing unchanged.
